// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared state, opcode and IR field definitions for the control sequencer
package control_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_HALT = 4'd8
   } state_e;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_ROL  = 5'b00100;
   localparam logic [4:0] OP_ROR  = 5'b00101;
   localparam logic [4:0] OP_SHR  = 5'b00110;
   localparam logic [4:0] OP_SHRA = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01000;
   localparam logic [4:0] OP_MUL  = 5'b01001;
   localparam logic [4:0] OP_DIV  = 5'b01010;
   localparam logic [4:0] OP_NEG  = 5'b01011;
   localparam logic [4:0] OP_NOT  = 5'b01100;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int ALU_W    = 13;
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_AND  = 2;
   localparam int ALU_OR   = 3;
   localparam int ALU_ROL  = 4;
   localparam int ALU_ROR  = 5;
   localparam int ALU_SHR  = 6;
   localparam int ALU_SHRA = 7;
   localparam int ALU_SHL  = 8;
   localparam int ALU_MUL  = 9;
   localparam int ALU_DIV  = 10;
   localparam int ALU_NEG  = 11;
   localparam int ALU_NOT  = 12;

   localparam int OPC_LSB = 27;
   localparam int RA_LSB  = 23;
   localparam int RB_LSB  = 19;
   localparam int RC_LSB  = 15;

   function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] op);
      logic [ALU_W-1:0] r;
      r = '0;
      case (op)
         OP_ADD:  r[ALU_ADD]  = 1'b1;
         OP_SUB:  r[ALU_SUB]  = 1'b1;
         OP_AND:  r[ALU_AND]  = 1'b1;
         OP_OR:   r[ALU_OR]   = 1'b1;
         OP_ROL:  r[ALU_ROL]  = 1'b1;
         OP_ROR:  r[ALU_ROR]  = 1'b1;
         OP_SHR:  r[ALU_SHR]  = 1'b1;
         OP_SHRA: r[ALU_SHRA] = 1'b1;
         OP_SHL:  r[ALU_SHL]  = 1'b1;
         OP_MUL:  r[ALU_MUL]  = 1'b1;
         OP_DIV:  r[ALU_DIV]  = 1'b1;
         OP_NEG:  r[ALU_NEG]  = 1'b1;
         OP_NOT:  r[ALU_NOT]  = 1'b1;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - sequencer to datapath control bundle
interface control_sequencer_if #(
   parameter int NREGS = 16
);
   logic             run;
   logic             mem_ready;
   logic [31:0]      IR;
   logic [NREGS-1:0] Rout;
   logic [NREGS-1:0] Rin;
   logic             PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
   logic             PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin;
   logic             Read, IncPC;
   logic [12:0]      alu_op;
   logic             halted;
   logic             illegal;

   modport master (
      input  run, mem_ready, IR,
      output Rout, Rin, PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
      output PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin,
      output Read, IncPC, alu_op, halted, illegal
   );

   modport slave (
      output run, mem_ready, IR,
      input  Rout, Rin, PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
      input  PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin,
      input  Read, IncPC, alu_op, halted, illegal
   );
endinterface

// File: rtl/reg_decoder_4to16.sv
// rtl/reg_decoder_4to16.sv - gated 4-to-16 one-hot register select decoder
module reg_decoder_4to16 (
   input  logic [3:0]  sel,
   input  logic        en,
   output logic [15:0] onehot
);
   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end
endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore fetch/execute sequencer for the bus datapath
module control_sequencer
   import control_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int OPW   = 5
) (
   input  logic                clk,
   input  logic                reset,
   control_sequencer_if.master bus
);

   state_e          state;
   state_e          state_nxt;
   logic            illegal_q;

   logic [OPW-1:0]  opcode;
   logic [3:0]      ra, rb, rc;
   logic            is_alu, is_muldiv, is_unary, is_nop, is_halt, is_legal;

   logic [3:0]      rout_sel, rin_sel;
   logic            rout_en, rin_en;
   logic [15:0]     rout_dec, rin_dec;
   logic            unused_ir_bits;

   assign opcode = bus.IR[OPC_LSB +: OPW];
   assign ra     = bus.IR[RA_LSB +: 4];
   assign rb     = bus.IR[RB_LSB +: 4];
   assign rc     = bus.IR[RC_LSB +: 4];
   assign unused_ir_bits = ^bus.IR[14:0];

   assign is_alu    = (opcode <= OP_SHL);
   assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
   assign is_nop    = (opcode == OP_NOP);
   assign is_halt   = (opcode == OP_HALT);
   assign is_legal  = is_alu || is_muldiv || is_unary || is_nop || is_halt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_T3 && !is_legal) illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.run) state_nxt = ST_T0;
         ST_T0:   state_nxt = ST_T1;
         ST_T1:   if (bus.mem_ready) state_nxt = ST_T2;
         ST_T2:   state_nxt = ST_T3;
         ST_T3: begin
            if (is_nop)                      state_nxt = ST_T0;
            else if (is_halt || !is_legal)   state_nxt = ST_HALT;
            else if (is_unary)               state_nxt = ST_T5;
            else                             state_nxt = ST_T4;
         end
         ST_T4:   state_nxt = ST_T5;
         // MUL/DIV spend an extra cycle moving the high half of Z into HI
         ST_T5: begin
            if (is_muldiv)    state_nxt = ST_T6;
            else if (bus.run) state_nxt = ST_T0;
            else              state_nxt = ST_IDLE;
         end
         ST_T6:   state_nxt = bus.run ? ST_T0 : ST_IDLE;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      rout_en      = 1'b0;
      rout_sel     = rb;
      rin_en       = 1'b0;
      rin_sel      = ra;
      bus.PCout    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.Zhighout = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.HIout    = 1'b0;
      bus.LOout    = 1'b0;
      bus.PCin     = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.Zin      = 1'b0;
      bus.MARin    = 1'b0;
      bus.MDRin    = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.Read     = 1'b0;
      bus.IncPC    = 1'b0;
      bus.alu_op   = '0;
      bus.halted   = (state == ST_HALT);
      case (state)
         ST_T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.PCin  = 1'b1;
         end
         ST_T1: begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
         end
         ST_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         // NOP, HALT and illegal opcodes leave every strobe low in T3
         ST_T3: begin
            if (is_unary) begin
               rout_en    = 1'b1;
               bus.alu_op = alu_onehot(opcode);
               bus.Zin    = 1'b1;
            end else if (is_alu || is_muldiv) begin
               rout_en = 1'b1;
               bus.Yin = 1'b1;
            end
         end
         ST_T4: begin
            rout_en    = 1'b1;
            rout_sel   = rc;
            bus.alu_op = alu_onehot(opcode);
            bus.Zin    = 1'b1;
         end
         ST_T5: begin
            bus.Zlowout = 1'b1;
            if (is_muldiv) bus.LOin = 1'b1;
            else           rin_en   = 1'b1;
         end
         ST_T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
         end
         default: ;
      endcase
   end

   reg_decoder_4to16 u_rout_dec (
      .sel    (rout_sel),
      .en     (rout_en),
      .onehot (rout_dec)
   );

   reg_decoder_4to16 u_rin_dec (
      .sel    (rin_sel),
      .en     (rin_en),
      .onehot (rin_dec)
   );

   assign bus.Rout    = rout_dec[NREGS-1:0];
   assign bus.Rin     = rin_dec[NREGS-1:0];
   assign bus.illegal = illegal_q;

endmodule
